// File: rtl/timer_cmp_channels_if.sv
// Register access bus of the compare-channel timer block.
// master: wr_en/rd_en/tim_paddr/tim_pwdata/tim_pstrb; slave: tim_prdata/reg_error_flag.
interface timer_cmp_channels_if;
  logic        wr_en;
  logic        rd_en;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata;
  logic        reg_error_flag;

  modport master (
    output wr_en, rd_en, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_prdata, reg_error_flag
  );

  modport slave (
    input  wr_en, rd_en, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_prdata, reg_error_flag
  );
endinterface

// File: rtl/timer_cmp_channels.sv
// NUM_CH compare channels against an external counter: one-shot/periodic, ISR, irq.
// Ports: sys_clk, sys_rst_n, bus (register slave), cnt_val, ch_match, tim_int.
module timer_cmp_channels #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 64
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  timer_cmp_channels_if.slave        bus,
  input  logic [CNT_W-1:0]           cnt_val,
  output logic [NUM_CH-1:0]          ch_match,
  output logic                       tim_int
);

  logic [2:0]        r_ctrl [NUM_CH];
  logic [CNT_W-1:0]  r_cmp  [NUM_CH];
  logic [31:0]       r_per  [NUM_CH];
  logic [NUM_CH-1:0] r_hist;
  logic [NUM_CH-1:0] r_sts;
  logic [NUM_CH-1:0] r_ovr;
  logic [NUM_CH-1:0] r_match;

  logic [2:0]        w_ctrl_nx [NUM_CH];
  logic [CNT_W-1:0]  w_cmp_nx  [NUM_CH];
  logic [31:0]       w_per_nx  [NUM_CH];
  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_ev;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_ie;
  logic [NUM_CH-1:0] w_clr_sts;
  logic [NUM_CH-1:0] w_clr_ovr;
  logic [1:0]        w_off;
  logic              w_isr_sel;
  logic              w_ch_hit;
  logic              w_mapped;
  logic              w_lock;
  logic              w_per_zero;
  logic              w_wr_err;
  logic              w_wr_ok;
  logic [31:0]       w_rdata;
  logic [63:0]       w_rd_c;
  logic [63:0]       w_wr_c;

  function automatic logic [31:0] f_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  st
  );
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  assign w_off     = bus.tim_paddr[3:2];
  assign w_isr_sel = (bus.tim_paddr == 12'h0F0);
  assign w_ch_hit  = (bus.tim_paddr[11:8] == 4'h1) &&
                     (bus.tim_paddr[1:0] == 2'b00);

  always_comb begin
    w_sel = '0;
    w_raw = '0;
    w_ie  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_sel[n] = w_ch_hit && (bus.tim_paddr[7:4] == 4'(n));
      w_raw[n] = r_ctrl[n][0] && (cnt_val == r_cmp[n]);
      w_ie[n]  = r_ctrl[n][2];
    end
  end

  // Rising edge of raw match: a halted counter yields a single event.
  assign w_ev     = w_raw & ~r_hist;
  assign w_mapped = w_isr_sel | (|w_sel);

  always_comb begin
    w_lock     = 1'b0;
    w_per_zero = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_sel[n]) begin
        if (w_off != 2'd0 && r_ctrl[n][0] && r_ctrl[n][1])
          w_lock = 1'b1;
        if (w_off == 2'd3 &&
            f_merge(r_per[n], bus.tim_pwdata,
                    bus.tim_pstrb) == 32'h0)
          w_per_zero = 1'b1;
      end
    end
  end

  assign w_wr_err = !w_mapped || w_lock || w_per_zero;
  assign w_wr_ok  = bus.wr_en && !w_wr_err;

  assign bus.reg_error_flag = (bus.wr_en && w_wr_err) ||
                              (bus.rd_en && !w_mapped);

  always_comb begin
    w_rdata = '0;
    w_rd_c  = '0;
    if (w_isr_sel)
      w_rdata = {16'h0, 8'(r_ovr), 8'(r_sts)};
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_sel[n]) begin
        w_rd_c = 64'(r_cmp[n]);
        unique case (w_off)
          2'd0: w_rdata = {29'h0, r_ctrl[n]};
          2'd1: w_rdata = w_rd_c[31:0];
          2'd2: w_rdata = w_rd_c[63:32];
          2'd3: w_rdata = r_per[n];
        endcase
      end
    end
  end

  assign bus.tim_prdata = w_rdata;

  always_comb begin
    w_clr_sts = '0;
    w_clr_ovr = '0;
    if (bus.wr_en && w_isr_sel) begin
      if (bus.tim_pstrb[0])
        w_clr_sts = bus.tim_pwdata[NUM_CH-1:0];
      if (bus.tim_pstrb[1])
        w_clr_ovr = bus.tim_pwdata[8 +: NUM_CH];
    end
  end

  // Hardware reload/disable first, then software bytes overlay it.
  always_comb begin
    w_ctrl_nx = r_ctrl;
    w_cmp_nx  = r_cmp;
    w_per_nx  = r_per;
    w_wr_c    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_ev[n]) begin
        if (r_ctrl[n][1])
          w_cmp_nx[n] = r_cmp[n] + CNT_W'(r_per[n]);
        else
          w_ctrl_nx[n][0] = 1'b0;
      end
      if (w_wr_ok && w_sel[n]) begin
        w_wr_c = 64'(w_cmp_nx[n]);
        unique case (w_off)
          2'd0: begin
            if (bus.tim_pstrb[0])
              w_ctrl_nx[n] = bus.tim_pwdata[2:0];
          end
          2'd1: begin
            w_wr_c[31:0] = f_merge(w_wr_c[31:0],
              bus.tim_pwdata, bus.tim_pstrb);
            w_cmp_nx[n] = CNT_W'(w_wr_c);
          end
          2'd2: begin
            w_wr_c[63:32] = f_merge(w_wr_c[63:32],
              bus.tim_pwdata, bus.tim_pstrb);
            w_cmp_nx[n] = CNT_W'(w_wr_c);
          end
          2'd3: begin
            w_per_nx[n] = f_merge(r_per[n],
              bus.tim_pwdata, bus.tim_pstrb);
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hist  <= '0;
      r_sts   <= '0;
      r_ovr   <= '0;
      r_match <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_ctrl[n] <= '0;
        r_cmp[n]  <= '1;
        r_per[n]  <= 32'd1;
      end
    end else begin
      // ch_en=0 forces raw low, so the history clears with it.
      r_hist  <= w_raw;
      r_match <= w_ev;
      r_sts   <= (r_sts & ~w_clr_sts) | w_ev;
      r_ovr   <= (r_ovr & ~w_clr_ovr) |
                 (w_ev & r_sts & ~w_clr_sts);
      for (int n = 0; n < NUM_CH; n++) begin
        r_ctrl[n] <= w_ctrl_nx[n];
        r_cmp[n]  <= w_cmp_nx[n];
        r_per[n]  <= w_per_nx[n];
      end
    end
  end

  assign ch_match = r_match;
  assign tim_int  = |(r_sts & w_ie);

endmodule

// File: tb/tb_timer_cmp_channels.sv
// Bench for timer_cmp_channels: directed vectors, behavioural model,
// per-cycle compare of ch_match/tim_int/read data/error flag.
module tb_timer_cmp_channels;
  localparam int NCH = 4;
  localparam int CW  = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [CW-1:0]  cnt;
  logic [NCH-1:0] ch_match;
  logic           tim_int;

  timer_cmp_channels_if bus ();

  timer_cmp_channels #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus),
    .cnt_val   (cnt),
    .ch_match  (ch_match),
    .tim_int   (tim_int)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pc [NCH];
  logic [31:0] last_rd;
  logic        last_err;

  logic [2:0]     m_ctrl [NCH];
  logic [63:0]    m_cmp  [NCH];
  logic [31:0]    m_per  [NCH];
  logic [NCH-1:0] m_sts, m_ovr, m_prev, m_match;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o,
    input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  function automatic int ch_of(input logic [11:0] a);
    int ai;
    ai = int'(a);
    if (a[1:0] != 2'b00) return -1;
    if (ai < 'h100 || ai >= 'h100 + 16 * NCH) return -1;
    return (ai - 'h100) / 16;
  endfunction

  function automatic int off_of(input logic [11:0] a);
    return ((int'(a) - 'h100) % 16) / 4;
  endfunction

  function automatic logic exp_err(input logic w,
    input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    int off;
    if (a == 12'h0F0) return 1'b0;
    n = ch_of(a);
    if (n < 0) return 1'b1;
    if (!w) return 1'b0;
    off = off_of(a);
    if (off != 0 && m_ctrl[n][0] && m_ctrl[n][1]) return 1'b1;
    if (off == 3 && bmerge(m_per[n], d, s) == 32'h0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    int n;
    logic [63:0] c;
    if (a == 12'h0F0) return {16'h0, 8'(m_ovr), 8'(m_sts)};
    n = ch_of(a);
    if (n < 0) return 32'h0;
    c = m_cmp[n];
    case (off_of(a))
      0: return 32'(m_ctrl[n]);
      1: return c[31:0];
      2: return c[63:32];
      default: return m_per[n];
    endcase
  endfunction

  function automatic logic exp_int();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (m_sts[i] && m_ctrl[i][2]) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ctrl[i] = 3'b000;
      m_cmp[i]  = '1;
      m_per[i]  = 32'd1;
    end
    m_sts = '0; m_ovr = '0; m_prev = '0; m_match = '0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] raw, ev, clr_s, clr_o;
    logic err;
    int n;
    logic [63:0] c;
    err = exp_err(bus.wr_en, bus.tim_paddr, bus.tim_pwdata,
                  bus.tim_pstrb);
    for (int i = 0; i < NCH; i++) begin
      raw[i] = m_ctrl[i][0] && (cnt == m_cmp[i]);
      ev[i]  = raw[i] && !m_prev[i];
    end
    clr_s = '0;
    clr_o = '0;
    if (bus.wr_en && bus.tim_paddr == 12'h0F0) begin
      if (bus.tim_pstrb[0]) clr_s = bus.tim_pwdata[NCH-1:0];
      if (bus.tim_pstrb[1]) clr_o = bus.tim_pwdata[8 +: NCH];
    end
    for (int i = 0; i < NCH; i++)
      if (ev[i]) begin
        if (m_ctrl[i][1]) m_cmp[i] = m_cmp[i] + 64'(m_per[i]);
        else m_ctrl[i][0] = 1'b0;
      end
    if (bus.wr_en && !err) begin
      n = ch_of(bus.tim_paddr);
      if (n >= 0) begin
        c = m_cmp[n];
        case (off_of(bus.tim_paddr))
          0: if (bus.tim_pstrb[0]) m_ctrl[n] = bus.tim_pwdata[2:0];
          1: begin
            c[31:0] = bmerge(c[31:0], bus.tim_pwdata, bus.tim_pstrb);
            m_cmp[n] = c;
          end
          2: begin
            c[63:32] = bmerge(c[63:32], bus.tim_pwdata, bus.tim_pstrb);
            m_cmp[n] = c;
          end
          default:
            m_per[n] = bmerge(m_per[n], bus.tim_pwdata, bus.tim_pstrb);
        endcase
      end
    end
    m_ovr   = (m_ovr & ~clr_o) | (ev & m_sts & ~clr_s);
    m_sts   = (m_sts & ~clr_s) | ev;
    m_match = ev;
    m_prev  = raw;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ch_match", 64'(ch_match), 64'(m_match));
    chk("tim_int", 64'(tim_int), 64'(exp_int()));
    if (bus.wr_en || bus.rd_en)
      chk("err_flag", 64'(bus.reg_error_flag),
          64'(exp_err(bus.wr_en, bus.tim_paddr, bus.tim_pwdata,
                      bus.tim_pstrb)));
    if (bus.rd_en)
      chk("rdata", 64'(bus.tim_prdata), 64'(exp_rd(bus.tim_paddr)));
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NCH; i++)
      if (ch_match[i] === 1'b1) pc[i]++;
  end

  task automatic cyc(input logic w, input logic r,
    input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.wr_en = w; bus.rd_en = r; bus.tim_paddr = a;
    bus.tim_pwdata = d; bus.tim_pstrb = s;
    #2;
    last_rd  = bus.tim_prdata;
    last_err = bus.reg_error_flag;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d, 4'hF);
  endtask

  task automatic wrs(input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    cyc(1'b1, 1'b0, a, d, s);
  endtask

  task automatic rd(input logic [11:0] a);
    cyc(1'b0, 1'b1, a, 32'h0, 4'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.tim_paddr = '0;
    bus.tim_pwdata = '0; bus.tim_pstrb = '0;
    cnt = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    rd(12'h100); chk("rst_ctrl0", 64'(last_rd), 64'h0);
    rd(12'h104); chk("rst_cmplo0", 64'(last_rd), 64'hFFFF_FFFF);
    rd(12'h108); chk("rst_cmphi0", 64'(last_rd), 64'hFFFF_FFFF);
    rd(12'h10C); chk("rst_per0", 64'(last_rd), 64'h1);
    rd(12'h0F0); chk("rst_isr", 64'(last_rd), 64'h0);

    // one-shot on ch0
    wr(12'h104, 32'h10);
    wr(12'h108, 32'h0);
    wr(12'h100, 32'h5);
    for (int c = 'h0C; c <= 'h14; c++) begin
      cnt = 64'(c);
      idle();
    end
    chk("os_pulses", 64'(pc[0]), 64'd1);
    rd(12'h0F0); chk("os_isr", 64'(last_rd), 64'h1);
    rd(12'h100); chk("os_ctrl", 64'(last_rd), 64'h4);
    chk("os_int", 64'(tim_int), 64'h1);

    // periodic on ch1
    wr(12'h114, 32'h20);
    wr(12'h118, 32'h0);
    wr(12'h11C, 32'h10);
    wr(12'h110, 32'h3);
    for (int c = 'h15; c <= 'h45; c++) begin
      cnt = 64'(c);
      idle();
    end
    chk("per_pulses", 64'(pc[1]), 64'd3);
    rd(12'h0F0); chk("per_isr", 64'(last_rd), 64'h203);
    rd(12'h114); chk("per_cmplo", 64'(last_rd), 64'h50);

    // access errors
    wr(12'h114, 32'h99); chk("e_cmp_lock", 64'(last_err), 64'h1);
    rd(12'h114); chk("e_cmp_keep", 64'(last_rd), 64'h50);
    wr(12'h118, 32'h5); chk("e_hi_lock", 64'(last_err), 64'h1);
    wrs(12'h10C, 32'h0, 4'h1); chk("e_per0_b", 64'(last_err), 64'h1);
    wr(12'h10C, 32'h0); chk("e_per0", 64'(last_err), 64'h1);
    rd(12'h10C); chk("e_per_keep", 64'(last_rd), 64'h1);
    wrs(12'h10C, 32'h0, 4'h2); chk("per_b1_ok", 64'(last_err), 64'h0);
    wr(12'h0F8, 32'h1234); chk("e_wr_0f8", 64'(last_err), 64'h1);
    rd(12'h0F8); chk("e_rd_0f8", 64'(last_err), 64'h1);
    chk("rd_0f8_zero", 64'(last_rd), 64'h0);
    rd(12'h140); chk("e_rd_ch4", 64'(last_err), 64'h1);
    rd(12'h102); chk("e_rd_misal", 64'(last_err), 64'h1);
    rd(12'h0F0); chk("e_isr_keep", 64'(last_rd), 64'h203);

    // W1C racing a new ch0 event
    wr(12'h100, 32'h5);
    cnt = 64'h10;
    wr(12'h0F0, 32'h1);
    idle();
    rd(12'h0F0);
    chk("w1c_race", 64'(last_rd & 32'h101), 64'h1);
    chk("w1c_pulses", 64'(pc[0]), 64'd2);

    // re-enable at an equal count
    wr(12'h100, 32'h5);
    idle();
    idle();
    chk("reen_pulses", 64'(pc[0]), 64'd3);
    wr(12'h0F0, 32'h0F0F);
    rd(12'h0F0); chk("isr_clr", 64'(last_rd), 64'h0);

    // software CTRL write beats one-shot auto-disable
    wr(12'h134, 32'h30);
    wr(12'h138, 32'h0);
    wr(12'h130, 32'h1);
    cnt = 64'h30;
    wr(12'h130, 32'h1);
    cnt = 64'h31;
    rd(12'h130); chk("sw_wins", 64'(last_rd), 64'h1);
    chk("sw_pulses", 64'(pc[3]), 64'd1);

    // 64-bit reload wraps
    wr(12'h124, 32'hFFFF_FFF8);
    wr(12'h128, 32'hFFFF_FFFF);
    wr(12'h12C, 32'h10);
    wr(12'h120, 32'h7);
    cnt = 64'hFFFF_FFFF_FFFF_FFF8;
    idle();
    idle();
    rd(12'h124); chk("wrap_lo", 64'(last_rd), 64'h8);
    rd(12'h128); chk("wrap_hi", 64'(last_rd), 64'h0);
    chk("wrap_int", 64'(tim_int), 64'h1);

    // reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("rst_match", 64'(ch_match), 64'h0);
    chk("rst_int", 64'(tim_int), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(12'h110); chk("rst2_ctrl1", 64'(last_rd), 64'h0);
    rd(12'h124); chk("rst2_lo2", 64'(last_rd), 64'hFFFF_FFFF);
    rd(12'h128); chk("rst2_hi2", 64'(last_rd), 64'hFFFF_FFFF);
    rd(12'h12C); chk("rst2_per2", 64'(last_rd), 64'h1);
    rd(12'h0F0); chk("rst2_isr", 64'(last_rd), 64'h0);

    // enable at a count already equal to the reset compare value
    cnt = '1;
    wr(12'h100, 32'h1);
    idle();
    idle();
    chk("post_rst_pulses", 64'(pc[0]), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_cmp_channels.md
TIMER_CMP_CHANNELS -- requirements
Module: timer_cmp_channels

Interface
REQ-001 Parameter NUM_CH, default 4, number of compare channels; legal range 1..8.
REQ-002 Parameter CNT_W, default 64, counter and compare width; legal values 32 or 64.
REQ-003 sys_clk  input  1  single clock; all state on its rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_en / rd_en  input  1 each  register write / read strobe, one cycle per access.
REQ-006 tim_paddr  input  12  byte address.
REQ-007 tim_pwdata  input  32  write data.
REQ-008 tim_pstrb  input  4  byte write strobes.
REQ-009 tim_prdata  output  32  combinational read data.
REQ-010 cnt_val  input  CNT_W  free-running counter value from the counter block.
REQ-011 reg_error_flag  output  1  combinational access error, valid with wr_en/rd_en.
REQ-012 ch_match  output  NUM_CH  one-cycle match pulse per channel.
REQ-013 tim_int  output  1  OR over channels of (status & int_en).

Function
REQ-014 Address map: channel n base = 0x100 + 0x10*n; +0x0 CTRL, +0x4 CMP_LO, +0x8 CMP_HI, +0xC PERIOD; 0x0F0 ISR.
REQ-015 CTRL bit0 ch_en, bit1 periodic mode, bit2 int_en; other bits read 0.
REQ-016 Compare register = {CMP_HI, CMP_LO}; when CNT_W=32, CMP_HI reads 0 and ignores writes.
REQ-017 ISR bits[NUM_CH-1:0] status, bits[8+NUM_CH-1:8] overrun; write-1-to-clear per bit; writes of 0 have no effect.
REQ-018 All writes honour tim_pstrb per byte; unstrobed bytes keep their value.
REQ-019 Raw match(n) = ch_en(n) & (cnt_val == cmp(n)); event(n) = raw match(n) & !raw match(n) registered one cycle earlier (rising-edge detect, so a halted counter yields one event).
REQ-020 Event(n) at cycle T: ch_match(n) = 1 and status(n) = 1 in cycle T+1.
REQ-021 Event while status(n) already 1 (not being cleared that cycle): overrun(n) set.
REQ-022 Same-cycle W1C of status(n) and event(n): status(n) stays 1, overrun(n) not set.
REQ-023 Periodic mode: on event(n), cmp(n) <= cmp(n) + PERIOD(n), modulo 2^CNT_W (wrap, no carry out).
REQ-024 One-shot mode: on event(n), ch_en(n) cleared by hardware in cycle T+1.
REQ-025 Same-cycle software write to CMP_LO/CMP_HI/CTRL and hardware reload/auto-disable of the same channel: software write wins per written byte.
REQ-026 Clearing ch_en clears the match-history flop so re-enable at an equal count produces an event.
REQ-027 reg_error_flag = 1 for: access (read or write) to an unmapped address; write of PERIOD with resulting value 0; write to CMP_LO/CMP_HI/PERIOD while ch_en=1 and periodic=1.
REQ-028 Erroring write updates no register state; ISR W1C is unaffected by errors elsewhere.
REQ-029 Unmapped reads return 0; channel addresses for n >= NUM_CH are unmapped.

Reset
REQ-030 On sys_rst_n low: CTRL=0, cmp=all ones, PERIOD=1, status=0, overrun=0, match history=0; ch_match=0, tim_int=0 immediately.
REQ-031 Reset mid-operation aborts any pending reload; first event after release requires a fresh rising edge of raw match.

Verification
REQ-032 Ch0 CMP=0x10, CTRL=0x5 (en, one-shot, int), count through 0x10 -> ch_match[0] pulse one cycle, ISR=0x1, tim_int=1, CTRL reads 0x4.
REQ-033 Ch1 CMP=0x20, PERIOD=0x10, CTRL=0x3, count to 0x40 -> three events at 0x20/0x30/0x40, ISR bit9 (overrun) set after second event with no clear.
REQ-034 CNT_W=64, CMP=0xFFFF_FFFF_FFFF_FFF8, PERIOD=0x10, periodic -> after event cmp reads 0x0000_0000_0000_0008.
REQ-035 W1C ISR=0x1 in same cycle as ch0 event -> ISR bit0 remains 1, bit8 remains 0.
REQ-036 Write PERIOD=0; write address 0x0F8; write CMP_LO with ch periodic and enabled -> reg_error_flag=1 each, registers unchanged.
REQ-037 Assert sys_rst_n low during periodic operation -> all outputs 0, registers at REQ-030 values.
